// File: rtl/issue_pair_reg.sv
// rtl/issue_pair_reg.sv - ID/EX pipeline register for a 2-way superscalar core with pair splitting
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   decode handshake for one instruction pair per cycle
//   a_*, b_*            decoded slot A / slot B fields (valid, op, operands, regs, wen)
//   ex_stall, flush     EX back-pressure and taken-branch kill
//   ex_a_*, ex_b_*      registered issue slots toward the two ALUs
//   split_count         saturating count of pairs that could not co-issue
//
// SPLIT_SAT is the counter ceiling; it stays at 16'hFFFF in the core and only
// exists so the saturation path can be exercised with a smaller ceiling.
module issue_pair_reg #(
  parameter int          XLEN      = 64,
  parameter int          RW        = 5,
  parameter logic [15:0] SPLIT_SAT = 16'hFFFF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            a_vld,
  input  logic            b_vld,
  input  logic [3:0]      a_opr,
  input  logic [3:0]      b_opr,
  input  logic [XLEN-1:0] a_op1,
  input  logic [XLEN-1:0] a_op2,
  input  logic [XLEN-1:0] b_op1,
  input  logic [XLEN-1:0] b_op2,
  input  logic [RW-1:0]   a_rs1,
  input  logic [RW-1:0]   a_rs2,
  input  logic [RW-1:0]   a_rd,
  input  logic [RW-1:0]   b_rs1,
  input  logic [RW-1:0]   b_rs2,
  input  logic [RW-1:0]   b_rd,
  input  logic            a_wen,
  input  logic            b_wen,
  input  logic            ex_stall,
  input  logic            flush,
  output logic            ex_a_vld,
  output logic            ex_b_vld,
  output logic [3:0]      ex_a_opr,
  output logic [3:0]      ex_b_opr,
  output logic [XLEN-1:0] ex_a_op1,
  output logic [XLEN-1:0] ex_a_op2,
  output logic [XLEN-1:0] ex_b_op1,
  output logic [XLEN-1:0] ex_b_op2,
  output logic [RW-1:0]   ex_a_rd,
  output logic [RW-1:0]   ex_b_rd,
  output logic            ex_a_wen,
  output logic            ex_b_wen,
  output logic [15:0]     split_count
);

  // Slot B held back by a split, issued alone on the following cycle.
  logic            pend_vld;
  logic [3:0]      pend_opr;
  logic [XLEN-1:0] pend_op1;
  logic [XLEN-1:0] pend_op2;
  logic [RW-1:0]   pend_rd;
  logic            pend_wen;

  logic b_is_br;
  logic hazard;
  logic split;

  // Slot A source indices only matter to earlier stages; operands arrive already read.
  logic unused_rs;
  assign unused_rs = ^{a_rs1, a_rs2};

  // Branch compares 0111..1010 may only execute on the branch-capable ALU (slot A).
  assign b_is_br = (b_opr >= 4'd7) && (b_opr <= 4'd10);

  // Writes to x0 are discarded, so they never create a RAW dependency.
  assign hazard = a_wen && (a_rd != '0) && ((b_rs1 == a_rd) || (b_rs2 == a_rd));
  assign split  = a_vld && b_vld && (hazard || b_is_br);

  assign in_ready = !rst && !flush && !ex_stall && !pend_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_a_vld    <= 1'b0;
      ex_b_vld    <= 1'b0;
      ex_a_opr    <= '0;
      ex_b_opr    <= '0;
      ex_a_op1    <= '0;
      ex_a_op2    <= '0;
      ex_b_op1    <= '0;
      ex_b_op2    <= '0;
      ex_a_rd     <= '0;
      ex_b_rd     <= '0;
      ex_a_wen    <= 1'b0;
      ex_b_wen    <= 1'b0;
      pend_vld    <= 1'b0;
      pend_opr    <= '0;
      pend_op1    <= '0;
      pend_op2    <= '0;
      pend_rd     <= '0;
      pend_wen    <= 1'b0;
      split_count <= '0;
    end else if (flush) begin
      // Only valids are killed; stale data behind a cleared valid is harmless.
      ex_a_vld <= 1'b0;
      ex_b_vld <= 1'b0;
      pend_vld <= 1'b0;
    end else if (ex_stall) begin
      // Hold everything, including the pending slot B.
    end else if (pend_vld) begin
      ex_a_vld <= 1'b1;
      ex_a_opr <= pend_opr;
      ex_a_op1 <= pend_op1;
      ex_a_op2 <= pend_op2;
      ex_a_rd  <= pend_rd;
      ex_a_wen <= pend_wen;
      ex_b_vld <= 1'b0;
      pend_vld <= 1'b0;
    end else if (in_valid) begin
      if (split) begin
        ex_a_vld <= 1'b1;
        ex_a_opr <= a_opr;
        ex_a_op1 <= a_op1;
        ex_a_op2 <= a_op2;
        ex_a_rd  <= a_rd;
        ex_a_wen <= a_wen;
        ex_b_vld <= 1'b0;
        pend_vld <= 1'b1;
        pend_opr <= b_opr;
        pend_op1 <= b_op1;
        pend_op2 <= b_op2;
        pend_rd  <= b_rd;
        pend_wen <= b_wen;
        if (split_count != SPLIT_SAT) begin
          split_count <= split_count + 16'd1;
        end
      end else if (!a_vld && b_vld) begin
        // Compact a lone slot B into slot A so a lone branch reaches the branch ALU.
        ex_a_vld <= 1'b1;
        ex_a_opr <= b_opr;
        ex_a_op1 <= b_op1;
        ex_a_op2 <= b_op2;
        ex_a_rd  <= b_rd;
        ex_a_wen <= b_wen;
        ex_b_vld <= 1'b0;
      end else begin
        ex_a_vld <= a_vld;
        ex_a_opr <= a_opr;
        ex_a_op1 <= a_op1;
        ex_a_op2 <= a_op2;
        ex_a_rd  <= a_rd;
        ex_a_wen <= a_wen;
        ex_b_vld <= b_vld;
        ex_b_opr <= b_opr;
        ex_b_op1 <= b_op1;
        ex_b_op2 <= b_op2;
        ex_b_rd  <= b_rd;
        ex_b_wen <= b_wen;
      end
    end else begin
      ex_a_vld <= 1'b0;
      ex_b_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_issue_pair_reg.sv
// tb/tb_issue_pair_reg.sv - self-checking bench for issue_pair_reg
module tb_issue_pair_reg;

  localparam logic [15:0] SAT = 16'd40;

  typedef struct {
    logic        vld;
    logic [3:0]  opr;
    logic [63:0] op1;
    logic [63:0] op2;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        wen;
  } instr_t;

  logic clk, rst, in_valid, in_ready;
  logic a_vld, b_vld, a_wen, b_wen, ex_stall, flush;
  logic [3:0] a_opr, b_opr;
  logic [63:0] a_op1, a_op2, b_op1, b_op2;
  logic [4:0] a_rs1, a_rs2, a_rd, b_rs1, b_rs2, b_rd;
  logic ex_a_vld, ex_b_vld, ex_a_wen, ex_b_wen;
  logic [3:0] ex_a_opr, ex_b_opr;
  logic [63:0] ex_a_op1, ex_a_op2, ex_b_op1, ex_b_op2;
  logic [4:0] ex_a_rd, ex_b_rd;
  logic [15:0] split_count;

  int checks = 0;
  int failures = 0;

  issue_pair_reg #(.XLEN(64), .RW(5), .SPLIT_SAT(SAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_vld(a_vld), .b_vld(b_vld), .a_opr(a_opr), .b_opr(b_opr),
    .a_op1(a_op1), .a_op2(a_op2), .b_op1(b_op1), .b_op2(b_op2),
    .a_rs1(a_rs1), .a_rs2(a_rs2), .a_rd(a_rd),
    .b_rs1(b_rs1), .b_rs2(b_rs2), .b_rd(b_rd),
    .a_wen(a_wen), .b_wen(b_wen), .ex_stall(ex_stall), .flush(flush),
    .ex_a_vld(ex_a_vld), .ex_b_vld(ex_b_vld), .ex_a_opr(ex_a_opr), .ex_b_opr(ex_b_opr),
    .ex_a_op1(ex_a_op1), .ex_a_op2(ex_a_op2), .ex_b_op1(ex_b_op1), .ex_b_op2(ex_b_op2),
    .ex_a_rd(ex_a_rd), .ex_b_rd(ex_b_rd), .ex_a_wen(ex_a_wen), .ex_b_wen(ex_b_wen),
    .split_count(split_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_a(input logic v, input logic [3:0] o, input logic [63:0] x1, input logic [63:0] x2,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d, input logic w);
    a_vld = v; a_opr = o; a_op1 = x1; a_op2 = x2; a_rs1 = s1; a_rs2 = s2; a_rd = d; a_wen = w;
  endtask

  task automatic set_b(input logic v, input logic [3:0] o, input logic [63:0] x1, input logic [63:0] x2,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d, input logic w);
    b_vld = v; b_opr = o; b_op1 = x1; b_op2 = x2; b_rs1 = s1; b_rs2 = s2; b_rd = d; b_wen = w;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; ex_stall = 1'b0; flush = 1'b0;
    set_a(1'b0, 4'd0, 64'd0, 64'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    set_b(1'b0, 4'd0, 64'd0, 64'd0, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  // Pair whose slot B reads slot A's destination: always splits.
  task automatic drive_raw_pair(input logic [63:0] a1, input logic [63:0] b1);
    in_valid = 1'b1;
    set_a(1'b1, 4'd0, a1, 64'd1, 5'd1, 5'd2, 5'd9, 1'b1);
    set_b(1'b1, 4'd1, b1, 64'd2, 5'd9, 5'd3, 5'd12, 1'b1);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_raw_pair(64'h11, 64'h22);
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    @(posedge clk); #1;
    checks++;
    if ({ex_a_vld, ex_b_vld, ex_a_opr, ex_b_opr, ex_a_op1, ex_a_op2, ex_b_op1, ex_b_op2,
         ex_a_rd, ex_b_rd, ex_a_wen, ex_b_wen} !== '0) begin
      failures++; $display("FAIL reset_ex_outputs got nonzero ex_a_vld=%b ex_b_vld=%b ex_a_op1=%h exp=0", ex_a_vld, ex_b_vld, ex_a_op1);
    end
    checks++; if (split_count !== 16'd0) begin failures++; $display("FAIL reset_split_count got=%0d exp=0", split_count); end
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_clean_pair();
    @(negedge clk);
    in_valid = 1'b1;
    set_a(1'b1, 4'd0, 64'd10, 64'd20, 5'd6, 5'd7, 5'd1, 1'b1);
    set_b(1'b1, 4'd3, 64'h55, 64'hAA, 5'd3, 5'd4, 5'd2, 1'b1);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL clean_in_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    checks++;
    if ({ex_a_vld, ex_b_vld, ex_a_op1, ex_b_opr, ex_b_op2, ex_b_rd} !== {1'b1, 1'b1, 64'd10, 4'd3, 64'hAA, 5'd2}) begin
      failures++; $display("FAIL clean_issue got a_vld=%b b_vld=%b a_op1=%h b_opr=%h b_op2=%h b_rd=%0d exp 1 1 a 3 aa 2",
                           ex_a_vld, ex_b_vld, ex_a_op1, ex_b_opr, ex_b_op2, ex_b_rd);
    end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL clean_ready_after got=%b exp=1", in_ready); end
    checks++; if (split_count !== 16'd0) begin failures++; $display("FAIL clean_count got=%0d exp=0", split_count); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_raw_split();
    @(negedge clk);
    in_valid = 1'b1;
    set_a(1'b1, 4'd0, 64'hA1, 64'hA2, 5'd1, 5'd2, 5'd5, 1'b1);
    set_b(1'b1, 4'd1, 64'hB1, 64'hB2, 5'd7, 5'd5, 5'd6, 1'b1);
    @(posedge clk); #1;
    checks++;
    if ({ex_a_vld, ex_b_vld, ex_a_op1, ex_a_rd} !== {1'b1, 1'b0, 64'hA1, 5'd5}) begin
      failures++; $display("FAIL raw_cycle1 got a_vld=%b b_vld=%b a_op1=%h a_rd=%0d exp 1 0 a1 5", ex_a_vld, ex_b_vld, ex_a_op1, ex_a_rd);
    end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL raw_in_ready_pending got=%b exp=0", in_ready); end
    @(negedge clk);
    set_a(1'b1, 4'd2, 64'hC1, 64'hC2, 5'd1, 5'd2, 5'd3, 1'b1);
    set_b(1'b1, 4'd3, 64'hD1, 64'hD2, 5'd4, 5'd6, 5'd8, 1'b1);
    @(posedge clk); #1;
    checks++;
    if ({ex_a_vld, ex_b_vld, ex_a_opr, ex_a_op1, ex_a_op2, ex_a_rd} !== {1'b1, 1'b0, 4'd1, 64'hB1, 64'hB2, 5'd6}) begin
      failures++; $display("FAIL raw_cycle2 got a_vld=%b b_vld=%b a_opr=%h a_op1=%h a_rd=%0d exp 1 0 1 b1 6",
                           ex_a_vld, ex_b_vld, ex_a_opr, ex_a_op1, ex_a_rd);
    end
    checks++; if (split_count !== 16'd1) begin failures++; $display("FAIL raw_count got=%0d exp=1", split_count); end
    @(negedge clk);
    idle_inputs();
    @(posedge clk); #1;
    checks++; if ({ex_a_vld, ex_b_vld} !== 2'b00) begin failures++; $display("FAIL raw_no_extra_accept got=%b%b exp=00", ex_a_vld, ex_b_vld); end
  endtask

  task automatic test_x0();
    @(negedge clk);
    in_valid = 1'b1;
    set_a(1'b1, 4'd0, 64'h1, 64'h2, 5'd3, 5'd4, 5'd0, 1'b1);
    set_b(1'b1, 4'd0, 64'h3, 64'h4, 5'd0, 5'd0, 5'd7, 1'b1);
    @(posedge clk); #1;
    checks++; if ({ex_a_vld, ex_b_vld} !== 2'b11) begin failures++; $display("FAIL x0_no_split got=%b%b exp=11", ex_a_vld, ex_b_vld); end
    checks++; if (split_count !== 16'd1) begin failures++; $display("FAIL x0_count got=%0d exp=1", split_count); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_branch_b();
    @(negedge clk);
    in_valid = 1'b1;
    set_a(1'b1, 4'd0, 64'hE1, 64'hE2, 5'd1, 5'd2, 5'd3, 1'b1);
    set_b(1'b1, 4'd8, 64'hF1, 64'hF2, 5'd4, 5'd6, 5'd0, 1'b0);
    @(posedge clk); #1;
    checks++; if ({ex_a_vld, ex_b_vld, ex_a_op1} !== {2'b10, 64'hE1}) begin failures++; $display("FAIL brb_cycle1 got=%b%b %h exp=10 e1", ex_a_vld, ex_b_vld, ex_a_op1); end
    @(negedge clk);
    idle_inputs();
    @(posedge clk); #1;
    checks++; if ({ex_a_vld, ex_b_vld, ex_a_opr, ex_a_op1} !== {2'b10, 4'd8, 64'hF1}) begin failures++; $display("FAIL brb_cycle2 got=%b%b %h %h exp=10 8 f1", ex_a_vld, ex_b_vld, ex_a_opr, ex_a_op1); end
    checks++; if (split_count !== 16'd2) begin failures++; $display("FAIL brb_count got=%0d exp=2", split_count); end
    @(negedge clk);
    in_valid = 1'b1;
    set_b(1'b1, 4'd7, 64'h71, 64'h72, 5'd4, 5'd6, 5'd0, 1'b0);
    @(posedge clk); #1;
    checks++; if ({ex_a_vld, ex_b_vld, ex_a_opr, ex_a_op2} !== {2'b10, 4'd7, 64'h72}) begin failures++; $display("FAIL lone_branch got=%b%b %h %h exp=10 7 72", ex_a_vld, ex_b_vld, ex_a_opr, ex_a_op2); end
    checks++; if (split_count !== 16'd2) begin failures++; $display("FAIL lone_branch_count got=%0d exp=2", split_count); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_stall_pending();
    @(negedge clk);
    drive_raw_pair(64'hAAA, 64'hBBB);
    @(posedge clk); #1;
    @(negedge clk);
    in_valid = 1'b0;
    ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready[%0d] got=%b exp=0", i, in_ready); end
      @(posedge clk); #1;
      checks++; if ({ex_a_vld, ex_b_vld, ex_a_op1} !== {2'b10, 64'hAAA}) begin failures++; $display("FAIL stall_hold[%0d] got=%b%b %h exp=10 aaa", i, ex_a_vld, ex_b_vld, ex_a_op1); end
      @(negedge clk);
    end
    ex_stall = 1'b0;
    @(posedge clk); #1;
    checks++; if ({ex_a_vld, ex_b_vld, ex_a_op1} !== {2'b10, 64'hBBB}) begin failures++; $display("FAIL stall_b_issue got=%b%b %h exp=10 bbb", ex_a_vld, ex_b_vld, ex_a_op1); end
    @(posedge clk); #1;
    checks++; if (ex_a_vld !== 1'b0) begin failures++; $display("FAIL stall_no_dup got=%b exp=0", ex_a_vld); end
    checks++; if (split_count !== 16'd3) begin failures++; $display("FAIL stall_count got=%0d exp=3", split_count); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    drive_raw_pair(64'h123, 64'h456);
    @(posedge clk); #1;
    @(negedge clk);
    flush = 1'b1;
    in_valid = 1'b1;
    set_a(1'b1, 4'd0, 64'h9, 64'h9, 5'd1, 5'd2, 5'd3, 1'b0);
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
    @(posedge clk); #1;
    checks++; if ({ex_a_vld, ex_b_vld} !== 2'b00) begin failures++; $display("FAIL flush_clear got=%b%b exp=00", ex_a_vld, ex_b_vld); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_ready_back got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    checks++; if (ex_a_vld !== 1'b0) begin failures++; $display("FAIL flush_pend_killed got=%b exp=0", ex_a_vld); end
    // Split pair presented together with flush: discarded, not counted.
    @(negedge clk);
    drive_raw_pair(64'h321, 64'h654);
    flush = 1'b1;
    @(posedge clk); #1;
    checks++; if ({ex_a_vld, split_count} !== {1'b0, 16'd4}) begin failures++; $display("FAIL flush_on_split got vld=%b cnt=%0d exp 0 4", ex_a_vld, split_count); end
    // Flush wins over stall.
    @(negedge clk);
    flush = 1'b0;
    set_b(1'b1, 4'd0, 64'h5, 64'h6, 5'd20, 5'd21, 5'd22, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    in_valid = 1'b0; ex_stall = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    checks++; if ({ex_a_vld, ex_b_vld} !== 2'b00) begin failures++; $display("FAIL flush_over_stall got=%b%b exp=00", ex_a_vld, ex_b_vld); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      drive_raw_pair(64'(i), 64'(i + 100));
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      @(posedge clk);
    end
    #1;
    checks++; if (split_count !== SAT) begin failures++; $display("FAIL saturation got=%0d exp=%0d", split_count, SAT); end
  endtask

  task automatic rand_instr(output instr_t x);
    x.vld = ($urandom_range(0, 99) < 85);
    x.opr = 4'($urandom_range(0, 15));
    x.op1 = {$urandom, $urandom};
    x.op2 = {$urandom, $urandom};
    x.rs1 = 5'($urandom_range(0, 7));
    x.rs2 = 5'($urandom_range(0, 7));
    x.rd  = 5'($urandom_range(0, 7));
    x.wen = 1'($urandom_range(0, 1));
  endtask

  task automatic test_random();
    instr_t ma, mb, ra, rb;
    instr_t pq[$];
    instr_t grp[$];
    logic [15:0] cnt;
    logic iv, st, fl, exp_rdy;
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ma = '{default: '0};
    mb = '{default: '0};
    cnt = 16'd0;
    for (int i = 0; i < 3000; i++) begin
      rand_instr(ra);
      rand_instr(rb);
      iv = ($urandom_range(0, 9) < 8);
      st = ($urandom_range(0, 4) == 0);
      fl = ($urandom_range(0, 11) == 0);
      in_valid = iv; ex_stall = st; flush = fl;
      set_a(ra.vld, ra.opr, ra.op1, ra.op2, ra.rs1, ra.rs2, ra.rd, ra.wen);
      set_b(rb.vld, rb.opr, rb.op1, rb.op2, rb.rs1, rb.rs2, rb.rd, rb.wen);
      #1;
      exp_rdy = !fl && !st && (pq.size() == 0);
      checks++; if (in_ready !== exp_rdy) begin failures++; $display("FAIL rand_in_ready[%0d] got=%b exp=%b", i, in_ready, exp_rdy); end
      @(posedge clk);
      if (fl) begin
        ma.vld = 1'b0; mb.vld = 1'b0; pq.delete();
      end else if (st) begin
      end else if (pq.size() != 0) begin
        ma = pq.pop_front(); mb.vld = 1'b0;
      end else if (iv) begin
        if (ra.vld && rb.vld &&
            ((ra.wen && ra.rd != 0 && (rb.rs1 == ra.rd || rb.rs2 == ra.rd)) || (rb.opr >= 7 && rb.opr <= 10))) begin
          ma = ra; mb.vld = 1'b0; pq.push_back(rb);
          if (cnt < SAT) cnt = cnt + 16'd1;
        end else begin
          grp.delete();
          if (ra.vld) grp.push_back(ra);
          if (rb.vld) grp.push_back(rb);
          ma.vld = 1'b0; mb.vld = 1'b0;
          if (grp.size() > 0) ma = grp[0];
          if (grp.size() > 1) mb = grp[1];
        end
      end else begin
        ma.vld = 1'b0; mb.vld = 1'b0;
      end
      #1;
      checks++; if ({ex_a_vld, ex_b_vld} !== {ma.vld, mb.vld}) begin failures++; $display("FAIL rand_valids[%0d] got=%b%b exp=%b%b", i, ex_a_vld, ex_b_vld, ma.vld, mb.vld); end
      if (ma.vld) begin
        checks++;
        if ({ex_a_opr, ex_a_op1, ex_a_op2, ex_a_rd, ex_a_wen} !== {ma.opr, ma.op1, ma.op2, ma.rd, ma.wen}) begin
          failures++; $display("FAIL rand_slot_a[%0d] got=%h %h %h %0d %b exp=%h %h %h %0d %b", i,
                               ex_a_opr, ex_a_op1, ex_a_op2, ex_a_rd, ex_a_wen, ma.opr, ma.op1, ma.op2, ma.rd, ma.wen);
        end
      end
      if (mb.vld) begin
        checks++;
        if ({ex_b_opr, ex_b_op1, ex_b_op2, ex_b_rd, ex_b_wen} !== {mb.opr, mb.op1, mb.op2, mb.rd, mb.wen}) begin
          failures++; $display("FAIL rand_slot_b[%0d] got=%h %h %h %0d %b exp=%h %h %h %0d %b", i,
                               ex_b_opr, ex_b_op1, ex_b_op2, ex_b_rd, ex_b_wen, mb.opr, mb.op1, mb.op2, mb.rd, mb.wen);
        end
      end
      checks++; if (split_count !== cnt) begin failures++; $display("FAIL rand_count[%0d] got=%0d exp=%0d", i, split_count, cnt); end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_clean_pair();
    test_raw_split();
    test_x0();
    test_branch_b();
    test_stall_pending();
    test_flush();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
